// File: rtl/pow2_decode.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : pow2_decode                                                |
// | Description : log2-domain score to linear Q0.OUT_W probability, computed |
// |               as (1+f)*2^n over a two-stage valid/ready pipeline.        |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module pow2_decode #(
  parameter int IN_W      = 8,
  parameter int FRAC_BITS = 3,
  parameter int OUT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_last,
  output logic             out_sat,
  output logic             out_zero
);

  localparam int c_n_w    = IN_W - FRAC_BITS;
  localparam int c_wide_w = OUT_W + FRAC_BITS + 1;

  logic                 r_started;
  logic                 r_s1_valid;
  logic                 r_s1_sat;
  logic                 r_s1_last;
  logic [c_n_w-1:0]     r_s1_k;
  logic [FRAC_BITS-1:0] r_s1_frac;

  logic                 r_out_valid;
  logic [OUT_W-1:0]     r_out_data;
  logic                 r_out_last;
  logic                 r_out_sat;
  logic                 r_out_zero;

  logic                 w_adv1;
  logic                 w_adv2;
  logic [c_n_w-1:0]     w_n;
  logic [c_wide_w-1:0]  w_wide;
  logic [31:0]          w_shamt;
  logic                 w_k_big;
  logic [OUT_W-1:0]     w_data;

  assign w_adv2   = !r_out_valid || out_ready;
  assign w_adv1   = !r_s1_valid || w_adv2;
  // Held low through reset and for the first edge after release.
  assign in_ready = r_started && w_adv1;

  // The integer part of x is simply its upper bits (floor of x / 2^FRAC_BITS).
  assign w_n = in_data[IN_W-1:FRAC_BITS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_started  <= 1'b0;
      r_s1_valid <= 1'b0;
      r_s1_sat   <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_k     <= '0;
      r_s1_frac  <= '0;
    end else begin
      r_started <= 1'b1;
      if (w_adv1) begin
        r_s1_valid <= in_valid && r_started;
        r_s1_sat   <= ~in_data[IN_W-1];
        r_s1_last  <= in_last;
        r_s1_k     <= -w_n;
        r_s1_frac  <= in_data[FRAC_BITS-1:0];
      end
    end
  end

  always_comb begin
    w_wide  = {1'b1, r_s1_frac, {OUT_W{1'b0}}};
    w_shamt = 32'(FRAC_BITS) + 32'(r_s1_k);
    w_k_big = 32'(r_s1_k) > 32'(OUT_W);
    w_data  = OUT_W'(w_wide >> w_shamt);
    if (r_s1_sat) begin
      w_data = '1;
    end else if (w_k_big) begin
      w_data = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_out_sat   <= 1'b0;
      r_out_zero  <= 1'b0;
    end else if (w_adv2) begin
      r_out_valid <= r_s1_valid;
      r_out_data  <= w_data;
      r_out_last  <= r_s1_last;
      r_out_sat   <= r_s1_sat;
      r_out_zero  <= !r_s1_sat && w_k_big;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;
  assign out_sat   = r_out_sat;
  assign out_zero  = r_out_zero;

endmodule
`default_nettype wire

// File: tb/tb_pow2_decode.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_pow2_decode                                             |
// | Description : directed vector table, stall/reset sequences and a random  |
// |               valid/ready scoreboard run against pow2_decode.            |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_pow2_decode;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_last;
  logic [7:0]  in_data;
  logic        out_valid, out_ready, out_last, out_sat, out_zero;
  logic [15:0] out_data;

  logic        in8_valid, in8_ready, in8_last;
  logic [7:0]  in8_data;
  logic        out8_valid, out8_last, out8_sat, out8_zero;
  logic [7:0]  out8_data;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pow2_decode #(.IN_W(8), .FRAC_BITS(3), .OUT_W(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .out_sat(out_sat), .out_zero(out_zero)
  );

  pow2_decode #(.IN_W(8), .FRAC_BITS(3), .OUT_W(8)) dut8 (
    .clk(clk), .rst(rst),
    .in_valid(in8_valid), .in_ready(in8_ready), .in_data(in8_data), .in_last(in8_last),
    .out_valid(out8_valid), .out_ready(1'b1), .out_data(out8_data),
    .out_last(out8_last), .out_sat(out8_sat), .out_zero(out8_zero)
  );

  typedef struct {
    logic [7:0]  x;
    logic        last;
    logic [15:0] data;
    logic        sat;
    logic        zero;
  } vec_t;

  vec_t vecs[14];
  vec_t vec8[4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Independent model: floor((8+f) * 2^16 / 2^(3+k)), saturate for x >= 0.
  function automatic logic [18:0] model(input logic [7:0] x, input logic last);
    int     xi;
    int     n;
    int     f;
    int     k;
    longint v;
    xi = int'($signed(x));
    if (xi >= 0) return {last, 1'b1, 1'b0, 16'hFFFF};
    n = xi >>> 3;
    f = xi & 7;
    k = -n;
    if (k > 16) return {last, 1'b0, 1'b1, 16'h0000};
    v = (longint'(8 + f) << 16) >> (3 + k);
    return {last, 1'b0, 1'b0, 16'(v)};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [18:0] exp_q[$];
    logic [18:0] e;
    logic        prev_stall;
    logic [18:0] prev_out;
    int          sent;
    int          got;
    int          cyc;

    vecs[0]  = '{8'hF8, 1'b0, 16'h8000, 1'b0, 1'b0};
    vecs[1]  = '{8'hFF, 1'b0, 16'hF000, 1'b0, 1'b0};
    vecs[2]  = '{8'h00, 1'b0, 16'hFFFF, 1'b1, 1'b0};
    vecs[3]  = '{8'h05, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[4]  = '{8'h7F, 1'b0, 16'hFFFF, 1'b1, 1'b0};
    vecs[5]  = '{8'h80, 1'b0, 16'h0001, 1'b0, 1'b0};
    vecs[6]  = '{8'h81, 1'b0, 16'h0001, 1'b0, 1'b0};
    vecs[7]  = '{8'hF0, 1'b0, 16'h4000, 1'b0, 1'b0};
    vecs[8]  = '{8'hE8, 1'b0, 16'h2000, 1'b0, 1'b0};
    vecs[9]  = '{8'hFC, 1'b0, 16'hC000, 1'b0, 1'b0};
    vecs[10] = '{8'hF7, 1'b1, 16'h7800, 1'b0, 1'b0};
    vecs[11] = '{8'h88, 1'b0, 16'h0002, 1'b0, 1'b0};
    vecs[12] = '{8'h89, 1'b0, 16'h0002, 1'b0, 1'b0};
    vecs[13] = '{8'hFE, 1'b0, 16'hE000, 1'b0, 1'b0};

    vec8[0] = '{8'h80, 1'b0, 16'h0000, 1'b0, 1'b1};
    vec8[1] = '{8'hC0, 1'b0, 16'h0001, 1'b0, 1'b0};
    vec8[2] = '{8'hB8, 1'b1, 16'h0000, 1'b0, 1'b1};
    vec8[3] = '{8'hF8, 1'b0, 16'h0080, 1'b0, 1'b0};

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
    in8_valid = 1'b0; in8_data = '0; in8_last = 1'b0;

    // Reset state
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_sideband", {29'd0, out_last, out_sat, out_zero}, 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Directed table, one isolated sample each
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      chk("vec_in_ready", 32'(in_ready), 32'd1);
      in_valid = 1'b1; in_data = vecs[i].x; in_last = vecs[i].last;
      @(negedge clk);
      in_valid = 1'b0; in_last = 1'b0;
      chk("vec_latency_early", 32'(out_valid), 32'd0);
      @(negedge clk);
      chk("vec_out_valid", 32'(out_valid), 32'd1);
      chk($sformatf("vec%0d_data", i), 32'(out_data), 32'(vecs[i].data));
      chk($sformatf("vec%0d_flags", i), {29'd0, out_last, out_sat, out_zero},
          {29'd0, vecs[i].last, vecs[i].sat, vecs[i].zero});
    end

    // Narrow-output instance: underflow boundary at k = OUT_W
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in8_valid = 1'b1; in8_data = vec8[i].x; in8_last = vec8[i].last;
      @(negedge clk);
      in8_valid = 1'b0; in8_last = 1'b0;
      @(negedge clk);
      chk("w8_out_valid", 32'(out8_valid), 32'd1);
      chk($sformatf("w8_vec%0d_data", i), 32'(out8_data), 32'(vec8[i].data));
      chk($sformatf("w8_vec%0d_flags", i), {29'd0, out8_last, out8_sat, out8_zero},
          {29'd0, vec8[i].last, vec8[i].sat, vec8[i].zero});
    end

    // Stall with a full pipe, then release with concurrent accept
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'hF8; in_last = 1'b0;
    @(negedge clk);
    chk("stall_ready_1", 32'(in_ready), 32'd1);
    in_data = 8'hF0;
    @(negedge clk);
    in_data = 8'hE8;
    for (int c = 0; c < 4; c++) begin
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_out_valid", 32'(out_valid), 32'd1);
      chk("stall_out_data", 32'(out_data), 32'h8000);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    chk("release_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    chk("rel_b_valid", 32'(out_valid), 32'd1);
    chk("rel_b", {15'd0, out_last, out_data}, {15'd0, 1'b0, 16'h4000});
    in_data = 8'hFF; in_last = 1'b1;
    @(negedge clk);
    chk("rel_c_valid", 32'(out_valid), 32'd1);
    chk("rel_c", {15'd0, out_last, out_data}, {15'd0, 1'b0, 16'h2000});
    in_valid = 1'b0; in_last = 1'b0;
    @(negedge clk);
    chk("rel_d_valid", 32'(out_valid), 32'd1);
    chk("rel_d", {15'd0, out_last, out_data}, {15'd0, 1'b1, 16'hF000});
    @(negedge clk);
    chk("rel_drained", 32'(out_valid), 32'd0);

    // Reset with two samples in flight
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'hF8;
    @(negedge clk);
    in_data = 8'hF0;
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("midrst_no_ghost", 32'(out_valid), 32'd0);
    in_valid = 1'b1; in_data = 8'hF0;
    @(negedge clk);
    in_valid = 1'b0;
    chk("midrst_no_ghost2", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("midrst_valid", 32'(out_valid), 32'd1);
    chk("midrst_data", 32'(out_data), 32'h4000);
    @(negedge clk);
    chk("midrst_alone", 32'(out_valid), 32'd0);

    // Random valid/ready traffic against the model
    sent = 0; got = 0; cyc = 0; prev_stall = 1'b0; prev_out = '0;
    while (got < 2000 && cyc < 30000) begin
      @(negedge clk);
      cyc++;
      if (prev_stall) begin
        chk("stable_valid", 32'(out_valid), 32'd1);
        chk("stable_payload", 32'({out_last, out_sat, out_zero, out_data}), 32'(prev_out));
      end
      out_ready = ($urandom_range(0, 3) != 0);
      if (!(in_valid && !in_ready)) begin
        in_valid = (sent < 2000) && ($urandom_range(0, 3) != 0);
        in_data  = 8'($urandom);
        in_last  = ($urandom_range(0, 7) == 0);
      end
      #1;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("rand_unexpected_output", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("rand_sample", 32'({out_last, out_sat, out_zero, out_data}), 32'(e));
        end
        got++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(in_data, in_last));
        sent++;
      end
      prev_stall = out_valid && !out_ready;
      prev_out   = {out_last, out_sat, out_zero, out_data};
    end
    in_valid = 1'b0;
    chk("rand_count", 32'(got), 32'd2000);
    chk("rand_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
